// File: rtl/flb_code_monitor_if.sv
`default_nettype none
// =============================================================================
// Module   : flb_code_monitor_if
// Purpose  : FLB code bus plus monitor CSRs and decoded results. The
//            FLB_MON_MINMAX_EN macro adds the win_min/win_max signals.
// Revision : 1.0
// =============================================================================
interface flb_code_monitor_if #(
  parameter int MTRX_W = 64,
  parameter int BAND_W = 30,
  parameter int BCNT_W = 8
);
  logic [2:0]        os_thrm;
  logic [1:0]        os_bin;
  logic [MTRX_W-1:0] mtrx_thrm;
  logic [BAND_W-1:0] band_thrm;
  logic              csr_flb_sdm_thrm_en;
  logic              csr_mon_en;
  logic [1:0]        csr_mon_win;
  logic              csr_mon_clr;

  logic [4:0]        band_bin;
  logic [6:0]        mtrx_bin;
  logic [1:0]        os_val;
  logic [8:0]        fine_code;
  logic [18:0]       win_sum;
  logic [8:0]        win_avg;
  logic              win_valid;
  logic              bubble_err;
  logic [BCNT_W-1:0] bubble_cnt;
`ifdef FLB_MON_MINMAX_EN
  logic [8:0]        win_min;
  logic [8:0]        win_max;
`endif

  modport master (
    output os_thrm, os_bin, mtrx_thrm, band_thrm,
           csr_flb_sdm_thrm_en, csr_mon_en, csr_mon_win, csr_mon_clr,
    input  band_bin, mtrx_bin, os_val, fine_code, win_sum, win_avg,
           win_valid, bubble_err, bubble_cnt
`ifdef FLB_MON_MINMAX_EN
    , input win_min, win_max
`endif
  );

  modport slave (
    input  os_thrm, os_bin, mtrx_thrm, band_thrm,
           csr_flb_sdm_thrm_en, csr_mon_en, csr_mon_win, csr_mon_clr,
    output band_bin, mtrx_bin, os_val, fine_code, win_sum, win_avg,
           win_valid, bubble_err, bubble_cnt
`ifdef FLB_MON_MINMAX_EN
    , output win_min, win_max
`endif
  );
endinterface
`default_nettype wire

// File: rtl/flb_code_monitor.sv
`default_nettype none
// =============================================================================
// Module   : flb_code_monitor
// Purpose  : Decodes FLB thermometer codes, counts bubbles and averages the
//            fine code over 16/64/256/1024-sample windows. FLB_MON_MINMAX_EN
//            adds per-window min/max of the fine code.
// Revision : 1.0
// =============================================================================
module flb_code_monitor #(
  parameter int MTRX_W = 64,
  parameter int BAND_W = 30,
  parameter int BCNT_W = 8
) (
  input wire                nsh_clk,
  input wire                rst,
  flb_code_monitor_if.slave mon
);

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  function automatic logic [6:0] f_pop_mtrx(input logic [MTRX_W-1:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < MTRX_W; i++) cnt = cnt + 7'(v[i]);
    return cnt;
  endfunction

  function automatic logic [4:0] f_pop_band(input logic [BAND_W-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < BAND_W; i++) cnt = cnt + 5'(v[i]);
    return cnt;
  endfunction

  // A legal code has its ones contiguous from the LSB, so adding one
  // carries through all of them and leaves no overlapping bit.
  function automatic logic f_bub_mtrx(input logic [MTRX_W-1:0] v);
    return (v & (v + MTRX_W'(1))) != '0;
  endfunction

  function automatic logic f_bub_band(input logic [BAND_W-1:0] v);
    return (v & (v + BAND_W'(1))) != '0;
  endfunction

  // ---------------------------------------------------------------------------
  // S1: raw capture
  // ---------------------------------------------------------------------------
  logic [2:0]        r_s1_os_thrm;
  logic [1:0]        r_s1_os_bin;
  logic [MTRX_W-1:0] r_s1_mtrx;
  logic [BAND_W-1:0] r_s1_band;
  logic              r_s1_thrm_en;

  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_s1_os_thrm <= '0;
      r_s1_os_bin  <= '0;
      r_s1_mtrx    <= '0;
      r_s1_band    <= '0;
      r_s1_thrm_en <= 1'b0;
    end else begin
      r_s1_os_thrm <= mon.os_thrm;
      r_s1_os_bin  <= mon.os_bin;
      r_s1_mtrx    <= mon.mtrx_thrm;
      r_s1_band    <= mon.band_thrm;
      r_s1_thrm_en <= mon.csr_flb_sdm_thrm_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the S1 sample
  // ---------------------------------------------------------------------------
  logic [4:0] w_band_pc;
  logic [6:0] w_mtrx_pc;
  logic [1:0] w_os_pc;
  logic [1:0] w_os_val;
  logic [8:0] w_fine;
  logic       w_os_bub;
  logic       w_bubble;

  always_comb begin
    w_band_pc = f_pop_band(r_s1_band);
    w_mtrx_pc = f_pop_mtrx(r_s1_mtrx);
    w_os_pc   = {1'b0, r_s1_os_thrm[0]} + {1'b0, r_s1_os_thrm[1]} + {1'b0, r_s1_os_thrm[2]};
    w_os_val  = r_s1_thrm_en ? w_os_pc : r_s1_os_bin;
    w_fine    = {w_mtrx_pc, 2'b00} + {7'd0, w_os_val};
    w_os_bub  = (r_s1_os_thrm & (r_s1_os_thrm + 3'd1)) != 3'd0;
    w_bubble  = f_bub_mtrx(r_s1_mtrx) | f_bub_band(r_s1_band) | (r_s1_thrm_en & w_os_bub);
  end

  // ---------------------------------------------------------------------------
  // S2: decoded outputs and bubble bookkeeping
  // ---------------------------------------------------------------------------
  logic [4:0]        r_band_bin;
  logic [6:0]        r_mtrx_bin;
  logic [1:0]        r_os_val;
  logic [8:0]        r_fine_code;
  logic              r_bubble_err;
  logic [BCNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_band_bin  <= '0;
      r_mtrx_bin  <= '0;
      r_os_val    <= '0;
      r_fine_code <= '0;
    end else begin
      r_band_bin  <= w_band_pc;
      r_mtrx_bin  <= w_mtrx_pc;
      r_os_val    <= w_os_val;
      r_fine_code <= w_fine;
    end
  end

  // Clear has priority: a bubble arriving with the clear is dropped.
  always_ff @(posedge nsh_clk) begin
    if (rst || mon.csr_mon_clr) begin
      r_bubble_err <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (w_bubble) begin
      r_bubble_err <= 1'b1;
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + BCNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Window engine
  // ---------------------------------------------------------------------------
  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic        w_win_start;
  logic        w_accum;
  logic        w_win_done;
  logic [1:0]  r_win_sel;
  logic [9:0]  r_cnt;
  logic [18:0] r_acc;
  logic [9:0]  w_last;
  logic [18:0] w_sum;
  logic [8:0]  w_avg;
  logic [18:0] r_win_sum;
  logic [8:0]  r_win_avg;
  logic        r_win_valid;

  always_ff @(posedge nsh_clk) begin
    if (rst) r_state <= c_ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (mon.csr_mon_en)  w_state_nxt = c_ST_RUN;
      c_ST_RUN:  if (!mon.csr_mon_en) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_win_start = 1'b0;
    w_accum     = 1'b0;
    w_win_done  = 1'b0;
    case (r_state)
      c_ST_IDLE: w_win_start = mon.csr_mon_en;
      c_ST_RUN: begin
        w_accum    = mon.csr_mon_en;
        w_win_done = mon.csr_mon_en && (r_cnt == w_last);
      end
      default: ;
    endcase
  end

  always_comb begin
    w_sum = r_acc + {10'd0, r_fine_code};
    case (r_win_sel)
      2'd0:    begin w_last = 10'd15;   w_avg = w_sum[12:4];  end
      2'd1:    begin w_last = 10'd63;   w_avg = w_sum[14:6];  end
      2'd2:    begin w_last = 10'd255;  w_avg = w_sum[16:8];  end
      default: begin w_last = 10'd1023; w_avg = w_sum[18:10]; end
    endcase
  end

  // Window length is re-latched only when a window begins.
  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_win_sel   <= '0;
      r_win_sum   <= '0;
      r_win_avg   <= '0;
      r_win_valid <= 1'b0;
    end else begin
      r_win_valid <= w_win_done;
      if (w_win_start || w_win_done) begin
        r_acc     <= '0;
        r_cnt     <= '0;
        r_win_sel <= mon.csr_mon_win;
      end else if (w_accum) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 10'd1;
      end
      if (w_win_done) begin
        r_win_sum <= w_sum;
        r_win_avg <= w_avg;
      end
    end
  end

`ifdef FLB_MON_MINMAX_EN
  logic [8:0] r_trk_min;
  logic [8:0] r_trk_max;
  logic [8:0] w_cur_min;
  logic [8:0] w_cur_max;
  logic [8:0] r_win_min;
  logic [8:0] r_win_max;

  // First sample of a window seeds both trackers.
  always_comb begin
    if (r_cnt == 10'd0) begin
      w_cur_min = r_fine_code;
      w_cur_max = r_fine_code;
    end else begin
      w_cur_min = (r_fine_code < r_trk_min) ? r_fine_code : r_trk_min;
      w_cur_max = (r_fine_code > r_trk_max) ? r_fine_code : r_trk_max;
    end
  end

  always_ff @(posedge nsh_clk) begin
    if (rst) begin
      r_trk_min <= '0;
      r_trk_max <= '0;
      r_win_min <= '0;
      r_win_max <= '0;
    end else begin
      if (w_accum) begin
        r_trk_min <= w_cur_min;
        r_trk_max <= w_cur_max;
      end
      if (w_win_done) begin
        r_win_min <= w_cur_min;
        r_win_max <= w_cur_max;
      end
    end
  end

  assign mon.win_min = r_win_min;
  assign mon.win_max = r_win_max;
`endif

  assign mon.band_bin   = r_band_bin;
  assign mon.mtrx_bin   = r_mtrx_bin;
  assign mon.os_val     = r_os_val;
  assign mon.fine_code  = r_fine_code;
  assign mon.win_sum    = r_win_sum;
  assign mon.win_avg    = r_win_avg;
  assign mon.win_valid  = r_win_valid;
  assign mon.bubble_err = r_bubble_err;
  assign mon.bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: doc/flb_code_monitor.md
Name: flb_code_monitor

Overview:
Receive-side checker for the FLB thermometer outputs. It samples os_thrm/os_bin/mtrx_thrm/band_thrm in the nsh_clk domain and converts each thermometer code back to binary. It flags thermometer bubbles and averages the fine DCO code over a programmable window. It sits beside the DCO driver and feeds CSR readback and lock-detect logic.

Parameters:
MTRX_W, 64, matrix thermometer width
BAND_W, 30, band thermometer width
BCNT_W, 8, bubble counter width (saturating)

Ports:
nsh_clk  in  1  block clock, same clock that drives the FLB outputs
rst  in  1  synchronous, active-high reset
os_thrm  in  3  offset thermometer from FLB
os_bin  in  2  offset binary from FLB
mtrx_thrm  in  MTRX_W  matrix thermometer from FLB
band_thrm  in  BAND_W  band thermometer from FLB
csr_flb_sdm_thrm_en  in  1  1: offset taken from os_thrm; 0: from os_bin
csr_mon_en  in  1  window engine enable
csr_mon_win  in  2  window length N: 0=16, 1=64, 2=256, 3=1024 samples
csr_mon_clr  in  1  one-cycle clear of sticky error and counters
band_bin  out  5  popcount(band_thrm), 0..30
mtrx_bin  out  7  popcount(mtrx_thrm), 0..64
os_val  out  2  offset value, 0..3
fine_code  out  9  mtrx_bin*4 + os_val, 0..259
win_sum  out  19  sum of fine_code over the last completed window
win_avg  out  9  win_sum >> log2(N)
win_valid  out  1  one-cycle pulse when win_sum/win_avg update
bubble_err  out  1  sticky flag: any thermometer bubble seen
bubble_cnt  out  BCNT_W  saturating count of bubbled samples

Behaviour:
- Reset (rst=1 at a nsh_clk edge): every output is 0, the FSM goes to IDLE, and all pipeline registers are 0.
- Pipeline stage S1: register all code inputs every cycle, unconditionally.
- Pipeline stage S2: register popcounts, os_val, fine_code, and the bubble check.
- Latency: decoded outputs reflect inputs sampled 2 cycles earlier.
- os_val source:
  - csr_flb_sdm_thrm_en=1: os_val = popcount(os_thrm).
  - csr_flb_sdm_thrm_en=0: os_val = os_bin.
  - The mode bit is sampled in S1 together with the data.
- Bubble rule: a thermometer t is legal iff (t & (t+1)) == 0, i.e. ones are contiguous from the LSB. All-zero and all-one are legal.
  - The check applies to mtrx_thrm and band_thrm, and to os_thrm only when thermometer mode is selected.
  - A sample with any illegal field increments bubble_cnt once; the counter saturates at all-ones.
  - Any illegal sample sets bubble_err.
  - Decoding still uses popcount on bubbled samples.
- csr_mon_clr clears bubble_err and bubble_cnt next cycle.
  - If a bubble arrives in the same cycle as the clear, the clear wins; that bubble is lost.
- Window FSM states: IDLE, RUN.
  - IDLE -> RUN when csr_mon_en=1. On entry, clear acc and cnt, and latch N from csr_mon_win.
  - RUN: each cycle acc += fine_code (S2 value) and cnt += 1.
  - When cnt == N-1, the cycle's sum (acc + fine_code) loads win_sum, win_avg = that sum >> log2(N), and win_valid=1 for one cycle.
  - The same cycle restarts with acc=0, cnt=0. Windows are back-to-back with no gap; each window is exactly N samples.
  - csr_mon_win changes are taken only at window start; a change mid-window is ignored until the next window.
  - csr_mon_en=0 in RUN -> IDLE next cycle. The partial window is discarded, no win_valid is issued, and win_sum/win_avg hold their last values.
  - rst mid-window returns to IDLE and clears the outputs.
- Width: acc is 19 bits. The maximum sum is 259*1024 = 265216 < 2^19, so no overflow is possible.

Optional Feature:
FLB_MON_MINMAX_EN
- Defined:
  - Adds outputs win_min and win_max, 9 bits each, reset 0.
  - Per window, track the min and max of fine_code. The trackers are seeded with the first sample of the window.
  - Both outputs load together with win_sum on win_valid.
  - An aborted window leaves them unchanged.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then inputs band_thrm=0x3FF, mtrx_thrm=0xFFFF, os_thrm=3'b011, thrm_en=1 -> after 2 cycles band_bin=10, mtrx_bin=16, os_val=2, fine_code=66; bubble_err=0.
- thrm_en=0, os_bin=3, os_thrm=3'b101 -> os_val=3 and no bubble counted (os_thrm is ignored in binary mode).
- mtrx_thrm=0x5 for 3 cycles, then csr_mon_clr -> bubble_cnt=3, bubble_err=1, both 0 the cycle after the clear; 300 bubbled samples -> bubble_cnt=255.
- csr_mon_win=0, csr_mon_en=1, fine_code alternating 100/101 -> win_valid every 16 cycles, win_sum=1608, win_avg=100.
- csr_mon_en dropped at sample 10 of a 64-sample window -> no win_valid; win_sum keeps its previous value; re-enable starts a fresh full window.
- csr_mon_win=3, all-ones mtrx (64) and os=3 -> win_sum=265216, win_avg=259; with FLB_MON_MINMAX_EN, win_min=win_max=259.
